// File: rtl/cct_transform_pkg.sv
// Shared types and helpers for the class-based transform pipeline.
//   op_e        : 3-bit operation code stored in the class table
//   default_op  : legacy (post-reset) table entry for a class index
//   transform   : applies an op to a word of run-time width n (n <= MAX_W)
package cct_transform_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_PASS      = 3'd0,
    OP_COMPL     = 3'd1,
    OP_SWAP_ENDS = 3'd2,
    OP_ROTL1     = 3'd3,
    OP_REVERSE   = 3'd4,
    OP_ZERO      = 3'd5,
    OP_RSVD6     = 3'd6,
    OP_RSVD7     = 3'd7
  } op_e;

  // Legacy mapping: first and last class pass through, classes 3..5
  // complement, everything else swaps the end bits.
  function automatic op_e default_op(input int cls, input int depth);
    op_e op;
    if (cls == 0 || cls == depth - 1) op = OP_PASS;
    else if (cls >= 3 && cls <= 5)    op = OP_COMPL;
    else                              op = OP_SWAP_ENDS;
    return op;
  endfunction

  // Word lives in the low n bits of x; bits above n are returned as zero.
  // Reserved codes fall through to PASS.
  function automatic logic [MAX_W-1:0] transform(input op_e op,
                                                 input logic [MAX_W-1:0] x,
                                                 input int n);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    r = x & mask;
    case (op)
      OP_COMPL: r = ~x & mask;
      OP_SWAP_ENDS: begin
        r = x & mask;
        r[0]   = x[n-1];
        r[n-1] = x[0];
      end
      OP_ROTL1: r = ((x << 1) | (x >> (n - 1))) & mask;
      OP_REVERSE: begin
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
          if (i < n) r[i] = x[n-1-i];
        end
      end
      OP_ZERO: r = '0;
      default: r = x & mask;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cct_misr.sv
// Galois-form multiple-input signature register.
//   clk, clear_n : clock, asynchronous active-low reset (sig -> SIG_SEED)
//   en           : fold data into the signature this cycle
//   load         : reload SIG_SEED; wins over en
//   data         : word to fold in, zero-extended to SIG_WIDTH
//   sig          : current signature
module cct_misr #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0]  SIG_POLY   = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]  SIG_SEED   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [SIG_WIDTH-1:0]  sig
);

  logic [SIG_WIDTH-1:0] sig_q, sig_d, fb;

  always_comb begin
    fb    = sig_q[SIG_WIDTH-1] ? SIG_POLY : '0;
    sig_d = sig_q;
    if (load)    sig_d = SIG_SEED;
    else if (en) sig_d = ({sig_q[SIG_WIDTH-2:0], 1'b0} ^ fb) ^ SIG_WIDTH'(data);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) sig_q <= SIG_SEED;
    else          sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/cct_transform_pipe.sv
// Two-stage class-based transform pipeline with output signature.
//   clk, clear_n : clock, asynchronous active-low reset
//   flush        : synchronous drop of both stages, cct_output -> 0
//   in_valid, cct_input : input word (one per cycle, no backpressure)
//   cfg_we, cfg_addr, cfg_op : class table write port
//   sig_clear    : reload signature to SIG_SEED
//   out_valid, cct_output : registered result, latency 2
//   signature    : MISR over every valid output
// Handshake: in_valid qualifies cct_input in the cycle it is high and the
// word is always taken (no ready); out_valid is high for exactly one cycle
// per accepted word, two edges later, unless flush or reset intervenes.
module cct_transform_pipe
  import cct_transform_pkg::*;
#(
  parameter int                   WIDTH      = 8,
  parameter int                   CLASS_BITS = 3,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY   = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SIG_SEED   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      cct_input,
  input  logic                  cfg_we,
  input  logic [CLASS_BITS-1:0] cfg_addr,
  input  logic [2:0]            cfg_op,
  input  logic                  sig_clear,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      cct_output,
  output logic [SIG_WIDTH-1:0]  signature
);

  localparam int DEPTH = 1 << CLASS_BITS;

  op_e                   table_q [DEPTH];
  op_e                   table_d [DEPTH];
  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]      s1_data_q, s1_data_d;
  op_e                   s1_op_q, s1_op_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      cct_output_q, cct_output_d;
  logic [CLASS_BITS-1:0] in_class;
  logic [MAX_W-1:0]      xform_wide;

  assign in_class = cct_input[WIDTH-1 -: CLASS_BITS];

  always_comb begin
    table_d = table_q;
    if (cfg_we) table_d[cfg_addr] = op_e'(cfg_op);

    // Lookup reads table_q, so a word arriving alongside a write to its
    // own class sees the entry as it was before this edge.
    s1_valid_d = in_valid & ~flush;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    if (in_valid && !flush) begin
      s1_data_d = cct_input;
      s1_op_d   = table_q[in_class];
    end

    xform_wide   = transform(s1_op_q, MAX_W'(s1_data_q), WIDTH);
    out_valid_d  = s1_valid_q & ~flush;
    cct_output_d = cct_output_q;
    if (flush)           cct_output_d = '0;
    else if (s1_valid_q) cct_output_d = xform_wide[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= default_op(i, DEPTH);
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_op_q      <= OP_PASS;
      out_valid_q  <= 1'b0;
      cct_output_q <= '0;
    end else begin
      table_q      <= table_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_op_q      <= s1_op_d;
      out_valid_q  <= out_valid_d;
      cct_output_q <= cct_output_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign cct_output = cct_output_q;

  cct_misr #(
    .DATA_WIDTH (WIDTH),
    .SIG_WIDTH  (SIG_WIDTH),
    .SIG_POLY   (SIG_POLY),
    .SIG_SEED   (SIG_SEED)
  ) u_misr (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (out_valid_q),
    .load    (sig_clear),
    .data    (cct_output_q),
    .sig     (signature)
  );

endmodule

// File: tb/tb_cct_transform_pipe.sv
module tb_cct_transform_pipe;

  logic        clk;
  logic        clear_n;
  logic        flush;
  logic        in_valid;
  logic [7:0]  cct_input;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_op;
  logic        sig_clear;
  logic        out_valid;
  logic [7:0]  cct_output;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [2:0] op;
    logic       vld;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [11];

  cct_transform_pipe dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .cct_input  (cct_input),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_op     (cfg_op),
    .sig_clear  (sig_clear),
    .out_valid  (out_valid),
    .cct_output (cct_output),
    .signature  (signature)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_n = 1'b1;
  endtask

  // ---------------- check / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] addr, input logic [2:0] op,
                       input logic vld, input logic [7:0] din,
                       input logic fl, input logic sc);
    @(posedge clk);
    #1;
    cfg_we = we; cfg_addr = addr; cfg_op = op;
    in_valid = vld; cct_input = din; flush = fl; sig_clear = sc;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic word(input logic [7:0] din, input logic [7:0] e);
    drive(1'b0, 3'd0, 3'd0, 1'b1, din, 1'b0, 1'b0);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (clear_n === 1'b1 && out_valid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", cct_output);
      end else begin
        check("out_data", 32'(cct_output), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    // class table / latency vectors: {we, addr, op, vld, din, exp}
    vecs[0]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'hE5, 8'hE5};
    vecs[1]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h65, 8'h9A};
    vecs[2]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h21, 8'hA0};
    vecs[3]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 3'd4, 3'd3, 1'b0, 8'h00, 8'h00};  // class 4 = ROTL1
    vecs[5]  = '{1'b1, 3'd1, 3'd4, 1'b0, 8'h00, 8'h00};  // class 1 = REVERSE
    vecs[6]  = '{1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h81, 8'h03};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h20, 8'h04};
    vecs[9]  = '{1'b1, 3'd3, 3'd5, 1'b1, 8'h65, 8'h9A};  // write ZERO, old entry used
    vecs[10] = '{1'b0, 3'd0, 3'd0, 1'b1, 8'h65, 8'h00};

    cfg_we = 0; cfg_addr = 0; cfg_op = 0; in_valid = 0; cct_input = 0;
    flush = 0; sig_clear = 0;
    do_reset();

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cct_output", 32'(cct_output), 32'd0);
    check("rst_signature", 32'(signature), 32'h0000);

    // legacy mapping, back-to-back words
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].op, vecs[i].vld, vecs[i].din, 1'b0, 1'b0);
      if (vecs[i].vld) exp_q.push_back(vecs[i].exp);
    end
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    check("valid_count_4", 32'(vcount), 32'd4);

    // table writes, including write-with-word in the same cycle
    for (int i = 4; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].op, vecs[i].vld, vecs[i].din, 1'b0, 1'b0);
      if (vecs[i].vld) exp_q.push_back(vecs[i].exp);
    end
    idle();
    wait_drain();

    // signature with default table from seed 0
    do_reset();
    word(8'h01, 8'h01); idle(); wait_drain(); @(negedge clk);
    check("sig_first", 32'(signature), 32'h0001);
    word(8'h01, 8'h01); idle(); wait_drain(); @(negedge clk);
    check("sig_second", 32'(signature), 32'h0003);

    drive(1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("sig_clear_idle", 32'(signature), 32'h0000);

    // 0x01 then fifteen zeros shifts the 1 up to the MSB
    word(8'h01, 8'h01);
    for (int i = 0; i < 15; i++) word(8'h00, 8'h00);
    idle(); wait_drain(); @(negedge clk);
    check("sig_preload", 32'(signature), 32'h8000);
    word(8'h00, 8'h00); idle(); wait_drain(); @(negedge clk);
    check("sig_feedback", 32'(signature), 32'h1021);

    // sig_clear in the cycle the output is valid: update is lost
    word(8'h01, 8'h01);
    idle();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("sig_clear_prio", 32'(signature), 32'h0000);
    wait_drain();

    // flush one cycle after a word, with a second word dropped
    word(8'h01, 8'h01); idle(); wait_drain(); @(negedge clk);
    check("sig_pre_flush", 32'(signature), 32'h0001);
    vcount = 0;
    drive(1'b0, 3'd0, 3'd0, 1'b1, 8'h65, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 8'h21, 1'b1, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    check("flush_valid_count", 32'(vcount), 32'd0);
    check("flush_cct_output", 32'(cct_output), 32'd0);
    check("flush_signature", 32'(signature), 32'h0001);

    // async reset between edges, mid-stream
    drive(1'b1, 3'd3, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
    word(8'h65, 8'h00);
    word(8'h65, 8'h00);
    word(8'hE5, 8'hE5);
    word(8'hE5, 8'hE5);
    idle();
    @(posedge clk);
    #3;
    clear_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_cct_output", 32'(cct_output), 32'd0);
    check("async_signature", 32'(signature), 32'h0000);
    #2 clear_n = 1'b1;
    vcount = 0;
    word(8'h65, 8'h9A);
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    check("post_reset_count", 32'(vcount), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cct_transform_pipe.md
Name: cct_transform_pipe

Overview:
- Parametrised, pipelined successor to the class-based byte transform circuit.
- The top CLASS_BITS of each input word select an entry in a programmable class-to-operation table. The selected operation is applied and the result is registered.
- Every valid output is compressed into a Galois MISR signature, so a bench can check a whole stimulus run against one value.
- Sits between a stimulus source (LFSR or host) and a checker.

Parameters:
- WIDTH, 8, data word width (>= CLASS_BITS+2).
- CLASS_BITS, 3, number of MSBs used as the class index; table depth is 2**CLASS_BITS.
- SIG_WIDTH, 16, signature width (>= WIDTH).
- SIG_POLY, 16'h1021, Galois feedback polynomial.
- SIG_SEED, 16'h0000, signature value after reset and after sig_clear.

Ports:
- clk  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush, active-high
- in_valid  in  1  cct_input is valid this cycle
- cct_input  in  WIDTH  data word
- cfg_we  in  1  table write strobe
- cfg_addr  in  CLASS_BITS  table entry to write
- cfg_op  in  3  operation code to write
- sig_clear  in  1  synchronous signature reload to SIG_SEED
- out_valid  out  1  cct_output is valid this cycle
- cct_output  out  WIDTH  transformed word, registered
- signature  out  SIG_WIDTH  current MISR value

Behaviour:
- Reset: clear_n low asynchronously forces:
  - out_valid=0, cct_output=0, signature=SIG_SEED, both pipeline stages invalid;
  - table to legacy mapping: classes 0 and 2**CLASS_BITS-1 PASS; classes 3..5 COMPL; all others SWAP_ENDS.
  - A reset mid-operation discards all in-flight words.
- Op codes (x = input word, N = WIDTH):
  - 0 PASS: x.
  - 1 COMPL: (2**N-1)-x, i.e. bitwise invert.
  - 2 SWAP_ENDS: {x[0], x[N-2:1], x[N-1]}.
  - 3 ROTL1: {x[N-2:0], x[N-1]}.
  - 4 REVERSE: bit-reversed x.
  - 5 ZERO: 0.
  - 6, 7 reserved: behave as PASS.
- Pipeline:
  - Stage 1 registers x and the op looked up from table[x[N-1:N-CLASS_BITS]].
  - Stage 2 registers the transform result into cct_output and asserts out_valid.
  - Latency: in_valid at cycle k gives out_valid at k+2.
  - Throughput is one word per cycle, with no backpressure.
- cct_output holds its last value while out_valid=0.
- Table write: cfg_we writes cfg_op into table[cfg_addr] at the clock edge.
  - A word accepted in the same cycle as a write to its own class uses the OLD entry.
  - The following cycle sees the new entry.
- Flush: at the edge, invalidates both stages and sets cct_output=0 and out_valid=0.
  - If in_valid is high in the same cycle, that word is dropped.
  - Table and signature are unaffected.
- Signature: on each cycle with out_valid=1, sig <= ({sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? SIG_POLY : 0)) ^ zero_ext(cct_output).
  - sig_clear has priority over an update in the same cycle; that update is lost.
  - The signature wraps freely with no saturation.

Decomposition:
- Package cct_transform_pkg: op_e enum (OP_PASS..OP_ZERO, 3 bits), a function giving the legacy default table entry for a class, and a transform function taking (op, word).
- One sub-module, cct_misr, parametrised SIG_WIDTH/SIG_POLY/SIG_SEED, with inputs en, load and data.
- The table and pipeline stay in the top level.

Test Plan:
- Reset, then feed 0xE5, 0x65, 0x21, 0x00 on consecutive cycles → outputs 0xE5, 0x9A, 0xA0, 0x00 on cycles k+2..k+5; out_valid is high for exactly 4 cycles.
- Write class 4 = ROTL1 and class 1 = REVERSE, wait 1 cycle, then feed 0x81 and 0x20 → 0x03 and 0x04.
  - Write class 3 = ZERO in the same cycle as input 0x65 → output 0x9A (old entry); next 0x65 → 0x00.
- Signature with defaults (seed 0): two valid outputs of 0x01 → 0x0001, then 0x0003.
  - Preload a stream so that sig=0x8000; next output 0x00 → 0x1021.
- Assert flush one cycle after in_valid 0x65 → no out_valid, cct_output=0x00, signature unchanged.
  - A word presented with flush is dropped.
- sig_clear in the same cycle as out_valid → signature = SIG_SEED.
- Deassert clear_n asynchronously mid-stream (between edges) → outputs, signature and table return to reset values immediately.
  - After release, legacy mapping is used again (0x65 → 0x9A).
